// File: rtl/xg_loop_loader.sv
// Purpose : captures one stream burst into a loop RAM, then kicks and waits for RAM replays.
// Latency : each accepted word is written to the RAM exactly 1 cycle after acceptance.
// Backpressure: s_ready is registered; it is high only in LOAD until the terminating word is taken.
// Option  : define XG_LOOP_LOADER_REPEAT_EN to replay loop_cnt+1 times; otherwise exactly one replay.
module xg_loop_loader #(
  parameter int WIDTH          = 417,
  parameter int MAX_DEPTH_BITS = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                loop_cnt,
  input  logic [WIDTH-1:0]          s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [WIDTH-1:0]          ram_din,
  output logic                      ram_wr_en,
  output logic [MAX_DEPTH_BITS-1:0] ram_wr_addr,
  output logic                      ram_rd_loop_en,
  input  logic                      loop_done,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [MAX_DEPTH_BITS:0]   depth
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    KICK   = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [MAX_DEPTH_BITS-1:0] LAST_ADDR = '1;
  localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE   = 1;
  localparam logic [MAX_DEPTH_BITS:0]   CNT_LAST  = {1'b0, LAST_ADDR};

  state_t                  state;
  state_t                  state_next;
  logic [MAX_DEPTH_BITS:0] wr_cnt;
  logic                    term_seen;
  logic                    loop_done_q;
  logic [7:0]              rem;
  logic [7:0]              rem_init;

  logic accept;
  logic at_cap;
  logic term_word;
  logic loop_rise;
  logic start_ok;

  assign accept    = s_valid && s_ready;
  assign at_cap    = (wr_cnt == CNT_LAST);
  assign term_word = accept && (s_last || at_cap);
  assign loop_rise = loop_done && !loop_done_q;
  assign start_ok  = (state == IDLE) && start;

`ifdef XG_LOOP_LOADER_REPEAT_EN
  // Extra replays beyond the first come from the sampled loop_cnt.
  assign rem_init = loop_cnt;
`else
  // Single replay: loop_cnt is deliberately not consumed.
  logic loop_cnt_unused;
  assign loop_cnt_unused = ^loop_cnt;
  assign rem_init        = 8'd0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (term_seen) state_next = KICK;
      KICK:    state_next = WAIT;
      WAIT:    if (loop_rise) state_next = (rem != 8'd0) ? KICK : FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy           = (state != IDLE);
    done           = (state == FINISH);
    ram_rd_loop_en = (state == KICK);
  end

  // Load datapath: write pipeline, counters, flags and replay bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready     <= 1'b0;
      ram_din     <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      wr_cnt      <= '0;
      depth       <= '0;
      overflow    <= 1'b0;
      term_seen   <= 1'b0;
      rem         <= 8'd0;
      loop_done_q <= 1'b0;
    end else begin
      ram_wr_en <= accept;
      if (accept) begin
        ram_din     <= s_data;
        ram_wr_addr <= wr_cnt[MAX_DEPTH_BITS-1:0];
      end

      if (start_ok) begin
        s_ready   <= 1'b1;
        wr_cnt    <= '0;
        depth     <= '0;
        overflow  <= 1'b0;
        term_seen <= 1'b0;
        rem       <= rem_init;
      end else begin
        if (state == LOAD) s_ready <= s_ready && !term_word;
        else               s_ready <= 1'b0;
        if (accept) begin
          wr_cnt <= wr_cnt + CNT_ONE;
          depth  <= wr_cnt + CNT_ONE;
        end
        if (term_word) term_seen <= 1'b1;
        if (accept && at_cap && !s_last) overflow <= 1'b1;
        if ((state == WAIT) && loop_rise && (rem != 8'd0)) rem <= rem - 8'd1;
      end

      // Edge detector history is wiped whenever a replay is kicked off.
      loop_done_q <= (state_next == KICK) ? 1'b0 : loop_done;
    end
  end

endmodule

// File: tb/tb_xg_loop_loader.sv
// Bench for xg_loop_loader: random stream loads scored against a queue of expected RAM writes.
// A monitor pops expectations on every ram_wr_en and counts kicks/done pulses.
// Replay count follows XG_LOOP_LOADER_REPEAT_EN the same way as the build under test.
`timescale 1ns/1ps
module tb_xg_loop_loader;
  localparam int W   = 417;
  localparam int DB  = 6;
  localparam int CAP = 1 << DB;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    loop_cnt;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [W-1:0]  ram_din;
  logic          ram_wr_en;
  logic [DB-1:0] ram_wr_addr;
  logic          ram_rd_loop_en;
  logic          loop_done;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [DB:0]   depth;

  int checks = 0;
  int errors = 0;
  int kick_cnt = 0;
  int done_cnt = 0;
  logic [DB-1:0] exp_addr[$];
  logic [W-1:0]  exp_data[$];

  xg_loop_loader #(.WIDTH(W), .MAX_DEPTH_BITS(DB)) dut (
    .clk(clk), .reset(reset), .start(start), .loop_cnt(loop_cnt),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .ram_din(ram_din), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_rd_loop_en(ram_rd_loop_en), .loop_done(loop_done), .busy(busy),
    .done(done), .overflow(overflow), .depth(depth)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < (W + 31) / 32; i++) w = {w[W-33:0], 32'($urandom())};
    return w;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, W'({s_ready, ram_wr_en, ram_rd_loop_en, busy, done, overflow}), '0);
    check({tag, "_din"}, ram_din, '0);
    check({tag, "_addr"}, W'(ram_wr_addr), '0);
    check({tag, "_depth"}, W'(depth), '0);
  endtask

  // Scoreboard monitor: every RAM write must match the oldest expected write.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ram_rd_loop_en) kick_cnt++;
      if (done) done_cnt++;
      if (ram_wr_en) begin
        if (exp_addr.size() == 0) begin
          check("spurious_write", W'(ram_wr_en), '0);
        end else begin
          check("wr_addr", W'(ram_wr_addr), W'(exp_addr.pop_front()));
          check("wr_data", ram_din, exp_data.pop_front());
        end
      end
    end
  end

  // One full load + replay sequence with the reference model inline.
  task automatic run_load(input string tag, input int n, input int last_idx, input int gap,
                          input int lcnt, input bit ld_high, input bit start_wait);
    int cnt;
    bit term;
    bit ovf;
    bit ok;
    int exp_k;
    int kb;
    int db;
    int want_k;
    logic [W-1:0] w;
    cnt = 0; term = 0; ovf = 0;
    kb = kick_cnt; db = done_cnt;
`ifdef XG_LOOP_LOADER_REPEAT_EN
    exp_k = lcnt + 1;
`else
    exp_k = 1;
`endif
    loop_done = ld_high;
    loop_cnt = 8'(lcnt);
    start = 1'b1;
    step();
    start = 1'b0;
    loop_cnt = 8'($urandom());
    for (int i = 0; i < n; i++) begin
      w = rand_word();
      s_valid = 1'b1; s_data = w; s_last = (i == last_idx);
      if (term) begin
        check({tag, "_ready_after_term"}, W'(s_ready), '0);
        step();
      end else begin
        ok = 0;
        for (int t = 0; t < 10 && !ok; t++) begin
          if (s_ready) begin
            exp_addr.push_back(DB'(cnt));
            exp_data.push_back(w);
            if (!s_last && cnt == CAP - 1) ovf = 1;
            term = s_last || (cnt == CAP - 1);
            cnt++;
            ok = 1;
          end
          step();
        end
        if (!ok) check({tag, "_ready_timeout"}, W'(s_ready), W'(1));
      end
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        s_valid = 1'b0; s_data = rand_word(); s_last = 1'($urandom());
        step();
      end
    end
    s_valid = 1'b0; s_last = 1'b0;

    for (int r = 0; r <= lcnt; r++) begin
      for (int t = 0; t < 12 && (kick_cnt - kb) <= r; t++) step();
      if (start_wait && r == 0) begin
        step();
        start = 1'b1; loop_cnt = 8'd5;
        step();
        start = 1'b0;
        check({tag, "_busy_in_wait"}, W'(busy), W'(1));
        check({tag, "_ready_in_wait"}, W'(s_ready), '0);
      end
      loop_done = 1'b0; step(); step();
      loop_done = 1'b1; step(); step();
      loop_done = 1'b0; step(); step();
      want_k = (r + 2 < exp_k) ? r + 2 : exp_k;
      check({tag, "_kicks"}, W'(kick_cnt - kb), W'(want_k));
      check({tag, "_done"}, W'(done_cnt - db), W'((r + 1 >= exp_k) ? 1 : 0));
    end
    step();
    check({tag, "_depth"}, W'(depth), W'(cnt));
    check({tag, "_overflow"}, W'(overflow), W'(ovf));
    check({tag, "_busy_end"}, W'(busy), '0);
    check({tag, "_writes_left"}, W'(exp_addr.size()), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; loop_cnt = 8'd0; s_data = '0;
    s_valid = 1'b0; s_last = 1'b0; loop_done = 1'b0;
    step(); step(); step();
    check_zero("por");
    reset = 1'b0;
    step();

    run_load("five", 5, 4, 0, 0, 0, 0);
    run_load("ovf", 70, -1, 0, 0, 0, 0);
    run_load("rep", 6, 5, 0, 2, 0, 0);

    // Reset in the middle of a load, then reload from address 0.
    loop_cnt = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_last = 1'b0; s_data = rand_word();
      check("rst_ready", W'(s_ready), W'(1));
      if (s_ready) begin
        exp_addr.push_back(DB'(i));
        exp_data.push_back(s_data);
      end
      step();
    end
    s_valid = 1'b0; reset = 1'b1;
    step();
    check_zero("midrst");
    reset = 1'b0;
    step();
    run_load("after_rst", 4, 3, 0, 1, 0, 0);

    run_load("wait_start", 8, 7, 2, 1, 1, 1);
    run_load("toggle", 6, 2, 1, 0, 0, 0);
    run_load("first_last", 1, 0, 0, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(1, 70));
      run_load("rand", n, int'($urandom_range(0, n - 1)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), 1'($urandom()), 0);
    end

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
